ball_centroid_calc: RTL and testbench

- Upstream neighbour of the servo driver.
- Consumes the binarized camera pixel stream in the LCD pixel-clock domain, which carries one target-colour hit bit per pixel.
- Per frame, tracks the bounding box of noise-filtered hit pixels and computes its centre.
- At each frame boundary, presents x_pos/y_pos with a one-cycle coor_valid_flag pulse; the servo driver edge-detects this pulse.

---
 rtl/ball_centroid_calc.sv | 185 ++++++++++++++++++
 tb/tb_ball_centroid_calc.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_centroid_calc.sv
// Tracks the bounding box of run-filtered target pixels in each frame and
// publishes its centre two cycles after every frame_vsync rising edge.
module ball_centroid_calc #(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 480,
    parameter int RUN_MIN    = 4,
    parameter int MIN_PIXELS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_vsync,
    input  logic        pix_de,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        pix_hit,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        coor_valid_flag,
    output logic        obj_found,
    output logic [18:0] hit_count
);
    localparam logic [10:0] H_LIM    = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM    = 11'(V_ACTIVE);
    localparam logic [3:0]  RUN_LIM  = 4'(RUN_MIN);
    localparam logic [9:0]  RUN_BACK = 10'(RUN_MIN - 1);
    localparam logic [18:0] MIN_CNT  = 19'(MIN_PIXELS);
    localparam logic [9:0]  X_RST    = 10'(H_ACTIVE / 2);
    localparam logic [9:0]  Y_RST    = 10'(V_ACTIVE / 2);
    localparam logic [9:0]  MIN_CLR  = 10'd1023;

    typedef enum logic [1:0] {IDLE, ACCUM, CALC} state_t;

    state_t      state_q, state_d;
    logic        vsync_q, vsync_d;
    logic [3:0]  run_q, run_d;
    logic [9:0]  xmin_q, xmin_d, xmax_q, xmax_d;
    logic [9:0]  ymin_q, ymin_d, ymax_q, ymax_d;
    logic [18:0] acc_cnt_q, acc_cnt_d;
    logic [9:0]  snap_xmin_q, snap_xmin_d, snap_xmax_q, snap_xmax_d;
    logic [9:0]  snap_ymin_q, snap_ymin_d, snap_ymax_q, snap_ymax_d;
    logic [18:0] snap_cnt_q, snap_cnt_d;
    logic [9:0]  x_pos_q, x_pos_d, y_pos_q, y_pos_d;
    logic        coor_valid_q, coor_valid_d;
    logic        obj_found_q, obj_found_d;
    logic [18:0] hit_count_q, hit_count_d;

    logic        frame_edge, qual_hit, run_reach, run_more, clear_acc;
    logic [9:0]  run_start;
    logic [19:0] cnt_sum;
    logic [10:0] x_sum, y_sum;

    assign frame_edge = frame_vsync & ~vsync_q;
    assign qual_hit   = pix_de & ~frame_vsync & pix_hit
                      & ({1'b0, pix_x} < H_LIM) & ({1'b0, pix_y} < V_LIM);
    assign run_reach  = qual_hit & (run_q == RUN_LIM - 4'd1);
    assign run_more   = qual_hit & (run_q == RUN_LIM);
    // The run is credited back to its first pixel once it proves long enough.
    assign run_start  = (pix_x >= RUN_BACK) ? pix_x - RUN_BACK : '0;
    assign cnt_sum    = {1'b0, acc_cnt_q} + (run_reach ? 20'(RUN_MIN) : 20'd1);
    assign x_sum      = {1'b0, snap_xmin_q} + {1'b0, snap_xmax_q};
    assign y_sum      = {1'b0, snap_ymin_q} + {1'b0, snap_ymax_q};

    always_comb begin
        // NOTE: every _d starts from its hold value so no path leaves it unassigned (no latches).
        state_d      = state_q;
        vsync_d      = frame_vsync;
        xmin_d       = xmin_q;
        xmax_d       = xmax_q;
        ymin_d       = ymin_q;
        ymax_d       = ymax_q;
        acc_cnt_d    = acc_cnt_q;
        snap_xmin_d  = snap_xmin_q;
        snap_xmax_d  = snap_xmax_q;
        snap_ymin_d  = snap_ymin_q;
        snap_ymax_d  = snap_ymax_q;
        snap_cnt_d   = snap_cnt_q;
        x_pos_d      = x_pos_q;
        y_pos_d      = y_pos_q;
        obj_found_d  = obj_found_q;
        hit_count_d  = hit_count_q;
        coor_valid_d = 1'b0;
        clear_acc    = 1'b0;

        if (qual_hit) run_d = (run_q == RUN_LIM) ? RUN_LIM : run_q + 4'd1;
        else          run_d = '0;

        if (run_reach) begin
            if (run_start < xmin_q) xmin_d = run_start;
            if (pix_y < ymin_q)     ymin_d = pix_y;
            if (pix_y > ymax_q)     ymax_d = pix_y;
        end
        if (run_reach | run_more) begin
            if (pix_x > xmax_q) xmax_d = pix_x;
            acc_cnt_d = cnt_sum[19] ? '1 : cnt_sum[18:0];
        end

        case (state_q)
            IDLE: begin
                if (frame_edge) begin
                    clear_acc = 1'b1;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                if (frame_edge) begin
                    snap_xmin_d = xmin_q;
                    snap_xmax_d = xmax_q;
                    snap_ymin_d = ymin_q;
                    snap_ymax_d = ymax_q;
                    snap_cnt_d  = acc_cnt_q;
                    clear_acc   = 1'b1;
                    state_d     = CALC;
                end
            end
            CALC: begin
                state_d     = ACCUM;
                hit_count_d = snap_cnt_q;
                obj_found_d = (snap_cnt_q >= MIN_CNT);
                if (snap_cnt_q >= MIN_CNT) begin
                    x_pos_d      = 10'(x_sum >> 1);
                    y_pos_d      = 10'(y_sum >> 1);
                    coor_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear_acc) begin
            xmin_d    = MIN_CLR;
            xmax_d    = '0;
            ymin_d    = MIN_CLR;
            ymax_d    = '0;
            acc_cnt_d = '0;
        end
    end

    // NOTE: flops update with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            run_q        <= '0;
            xmin_q       <= MIN_CLR;
            xmax_q       <= '0;
            ymin_q       <= MIN_CLR;
            ymax_q       <= '0;
            acc_cnt_q    <= '0;
            snap_xmin_q  <= MIN_CLR;
            snap_xmax_q  <= '0;
            snap_ymin_q  <= MIN_CLR;
            snap_ymax_q  <= '0;
            snap_cnt_q   <= '0;
            x_pos_q      <= X_RST;
            y_pos_q      <= Y_RST;
            coor_valid_q <= 1'b0;
            obj_found_q  <= 1'b0;
            hit_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            run_q        <= run_d;
            xmin_q       <= xmin_d;
            xmax_q       <= xmax_d;
            ymin_q       <= ymin_d;
            ymax_q       <= ymax_d;
            acc_cnt_q    <= acc_cnt_d;
            snap_xmin_q  <= snap_xmin_d;
            snap_xmax_q  <= snap_xmax_d;
            snap_ymin_q  <= snap_ymin_d;
            snap_ymax_q  <= snap_ymax_d;
            snap_cnt_q   <= snap_cnt_d;
            x_pos_q      <= x_pos_d;
            y_pos_q      <= y_pos_d;
            coor_valid_q <= coor_valid_d;
            obj_found_q  <= obj_found_d;
            hit_count_q  <= hit_count_d;
        end
    end

    assign x_pos           = x_pos_q;
    assign y_pos           = y_pos_q;
    assign coor_valid_flag = coor_valid_q;
    assign obj_found       = obj_found_q;
    assign hit_count       = hit_count_q;
endmodule

// File: tb/tb_ball_centroid_calc.sv
// Self-checking bench: run-length frame model plus per-cycle output comparison,
// pinned by hand-computed centroids for the directed frames.
module tb_ball_centroid_calc;
    localparam int H_ACTIVE   = 800;
    localparam int V_ACTIVE   = 480;
    localparam int RUN_MIN    = 4;
    localparam int MIN_PIXELS = 64;
    localparam int CNT_SAT    = (1 << 19) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_vsync, pix_de, pix_hit;
    logic [9:0]  pix_x, pix_y;
    logic [9:0]  x_pos, y_pos;
    logic        coor_valid_flag, obj_found;
    logic [18:0] hit_count;

    ball_centroid_calc #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
        .RUN_MIN(RUN_MIN), .MIN_PIXELS(MIN_PIXELS)
    ) dut (
        .clk(clk), .rst(rst), .frame_vsync(frame_vsync), .pix_de(pix_de),
        .pix_x(pix_x), .pix_y(pix_y), .pix_hit(pix_hit),
        .x_pos(x_pos), .y_pos(y_pos), .coor_valid_flag(coor_valid_flag),
        .obj_found(obj_found), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame model: counted runs are summarised per frame, results applied at E+2.
    bit line_pat [0:1023];
    int m_cnt, m_xmin, m_xmax, m_ymin, m_ymax;
    bit m_armed;
    int exp_x, exp_y, exp_cnt, pulse_cyc;
    bit exp_found;
    bit pend;
    int pend_cyc, pend_x, pend_y, pend_cnt;
    bit pend_found;
    int exp_pulses  = 0;
    int pulses_seen = 0;

    always @(posedge coor_valid_flag) pulses_seen++;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0; m_xmin = 1023; m_xmax = 0; m_ymin = 1023; m_ymax = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_armed = 0; pend = 0; pulse_cyc = -1;
        exp_x = H_ACTIVE / 2; exp_y = V_ACTIVE / 2; exp_cnt = 0; exp_found = 0;
    endtask

    task automatic model_run(input int y, input int xs, input int xe, input int len);
        m_cnt = (m_cnt + len > CNT_SAT) ? CNT_SAT : m_cnt + len;
        if (xs < m_xmin) m_xmin = xs;
        if (xe > m_xmax) m_xmax = xe;
        if (y < m_ymin)  m_ymin = y;
        if (y > m_ymax)  m_ymax = y;
    endtask

    task automatic set_pat(input int x0, input int x1);
        foreach (line_pat[i]) line_pat[i] = 0;
        for (int x = x0; x <= x1; x++) line_pat[x] = 1;
    endtask

    // Drives one contiguous segment of a line, then one blanking cycle.
    task automatic drive_line(input int y, input int x0, input int x1);
        int run_len;
        bit q;
        run_len = 0;
        for (int x = x0; x <= x1 + 1; x++) begin
            q = (x <= x1) && (x < H_ACTIVE) && (y < V_ACTIVE) && line_pat[x];
            if (q) run_len++;
            else begin
                if (run_len >= RUN_MIN) model_run(y, x - run_len, x - 1, run_len);
                run_len = 0;
            end
        end
        for (int x = x0; x <= x1; x++) begin
            @(posedge clk); #1;
            pix_de = 1; pix_x = 10'(x); pix_y = 10'(y); pix_hit = line_pat[x];
        end
        @(posedge clk); #1;
        pix_de = 0; pix_hit = 0;
    endtask

    // Raises frame_vsync for 'hold' cycles with in-range hits that must be ignored.
    task automatic frame_end(input int hold);
        @(posedge clk); #1;
        frame_vsync = 1;
        if (m_armed) begin
            pend       = 1;
            pend_cyc   = cyc + 2;
            pend_cnt   = m_cnt;
            pend_found = (m_cnt >= MIN_PIXELS);
            pend_x     = (m_xmin + m_xmax) / 2;
            pend_y     = (m_ymin + m_ymax) / 2;
            if (pend_found) exp_pulses++;
        end
        m_armed = 1;
        model_clear();
        for (int i = 0; i < hold; i++) begin
            pix_de = 1; pix_hit = 1; pix_x = 10'(100 + i % 16); pix_y = 10'd50;
            @(posedge clk); #1;
        end
        frame_vsync = 0; pix_de = 0; pix_hit = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic square_frame();
        for (int y = 50; y <= 69; y++) begin
            set_pat(100, 119);
            drive_line(y, 90, 129);
        end
    endtask

    task automatic random_frame();
        int x0, w, y0, h;
        x0 = $urandom_range(0, 805);
        w  = $urandom_range(3, 14);
        y0 = $urandom_range(0, 485);
        h  = $urandom_range(4, 16);
        for (int y = y0; y < y0 + h; y++) begin
            foreach (line_pat[i]) line_pat[i] = 0;
            for (int x = x0; x < x0 + w; x++) line_pat[x] = ($urandom_range(0, 9) != 0);
            drive_line(y, (x0 >= 4) ? x0 - 4 : 0, (x0 + w + 3 > 815) ? 815 : x0 + w + 3);
        end
    endtask

    task automatic check_outputs(input string tag, input int px, input int py,
                                 input int cnt, input int found);
        check({tag, "_x_pos"}, int'(x_pos), px);
        check({tag, "_y_pos"}, int'(y_pos), py);
        check({tag, "_hit_count"}, int'(hit_count), cnt);
        check({tag, "_obj_found"}, int'(obj_found), found);
    endtask

    // Compares every output against the model on every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            if (pend && cyc == pend_cyc) begin
                pend      = 0;
                exp_cnt   = pend_cnt;
                exp_found = pend_found;
                if (pend_found) begin
                    exp_x = pend_x; exp_y = pend_y; pulse_cyc = cyc;
                end
            end
            check("cyc_coor_valid_flag", int'(coor_valid_flag), (cyc == pulse_cyc) ? 1 : 0);
            check("cyc_x_pos", int'(x_pos), exp_x);
            check("cyc_y_pos", int'(y_pos), exp_y);
            check("cyc_hit_count", int'(hit_count), exp_cnt);
            check("cyc_obj_found", int'(obj_found), exp_found ? 1 : 0);
        end
    end

    initial begin
        int p0;
        frame_vsync = 0; pix_de = 0; pix_hit = 0; pix_x = '0; pix_y = '0;
        model_reset();
        foreach (line_pat[i]) line_pat[i] = 0;
        idle(3);
        check("reset_flag", int'(coor_valid_flag), 0);
        check_outputs("reset", 400, 240, 0, 0);
        rst = 0;

        // Two square frames: the first edge only arms the tracker.
        square_frame();
        p0 = pulses_seen; frame_end(4); idle(3);
        check("first_edge_pulses", pulses_seen - p0, 0);
        square_frame();
        p0 = pulses_seen; frame_end(4); idle(3);
        check("square_pulses", pulses_seen - p0, 1);
        check_outputs("square", 109, 59, 400, 1);

        // Isolated hits and runs of three never reach RUN_MIN.
        for (int y = 0; y < V_ACTIVE; y += 48) begin
            foreach (line_pat[i]) line_pat[i] = 0;
            for (int x = 0; x < H_ACTIVE; x++)
                line_pat[x] = (x % 10 == 0) || (x % 40 >= 24 && x % 40 <= 26);
            drive_line(y, 0, 799);
        end
        p0 = pulses_seen; frame_end(4); idle(3);
        check("noise_pulses", pulses_seen - p0, 0);
        check_outputs("noise", 109, 59, 0, 0);

        // Small object below MIN_PIXELS, then widened above it.
        for (int y = 300; y <= 309; y++) begin set_pat(600, 603); drive_line(y, 590, 620); end
        p0 = pulses_seen; frame_end(4); idle(3);
        check("small_pulses", pulses_seen - p0, 0);
        check_outputs("small", 109, 59, 40, 0);
        for (int y = 300; y <= 309; y++) begin set_pat(600, 607); drive_line(y, 590, 620); end
        p0 = pulses_seen; frame_end(4); idle(3);
        check("wide_pulses", pulses_seen - p0, 1);
        check_outputs("wide", 603, 304, 80, 1);

        // Hits straddling the right edge: only x 796..799 count.
        for (int y = 0; y <= 19; y++) begin set_pat(796, 810); drive_line(y, 790, 815); end
        p0 = pulses_seen; frame_end(4); idle(3);
        check("boundary_pulses", pulses_seen - p0, 1);
        check_outputs("boundary", 797, 9, 80, 1);

        // Long vsync with pix_de/pix_hit high accumulates nothing.
        p0 = pulses_seen; frame_end(40); idle(3);
        p0 = pulses_seen - p0;
        frame_end(40); idle(3);
        check("vsync_pulses", p0, 0);
        check_outputs("vsync", 797, 9, 0, 0);

        // Reset mid-frame returns outputs immediately and re-arms on the next edge.
        for (int y = 50; y <= 59; y++) begin set_pat(100, 119); drive_line(y, 90, 129); end
        @(posedge clk); #2;
        rst = 1;
        model_reset();
        #1;
        check("midrst_flag", int'(coor_valid_flag), 0);
        check_outputs("midrst", 400, 240, 0, 0);
        idle(3);
        rst = 0;
        square_frame();
        p0 = pulses_seen; frame_end(4); idle(3);
        check("post_rst_first_edge_pulses", pulses_seen - p0, 0);
        check_outputs("post_rst_first_edge", 400, 240, 0, 0);
        square_frame();
        p0 = pulses_seen; frame_end(4); idle(3);
        check("post_rst_pulses", pulses_seen - p0, 1);
        check_outputs("post_rst", 109, 59, 400, 1);

        // Alternating random-object and empty frames: each pulse seen once.
        p0 = pulses_seen;
        exp_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            random_frame();
            frame_end($urandom_range(2, 6)); idle(2);
            frame_end(3); idle(2);
        end
        idle(3);
        check("random_pulse_count", pulses_seen - p0, exp_pulses);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
